conv2d_tap_scheduler: RTL
=========================

// Module: conv2d_tap_scheduler
// PURPOSE
// Sequencer for a time-multiplexed conv2d: one multiply-accumulate per cycle instead of a fully unrolled array.
// Walks every output position and every kernel tap, issuing synchronous reads to the input, weight and bias RAMs.
// Accumulates bias + sum(input*weight) in an internal register, then presents each finished output on a valid/ready port.
// Sits between the tensor/weight/bias RAMs and the output buffer, controlled by a start/done pair.
// PARAMETERS
// BATCH_SIZE    1   number of images
// IN_CHANNELS   2   input channels (IC)
// OUT_CHANNELS  1   output channels (OC)
// IN_HEIGHT     4   input rows (IH)
// IN_WIDTH      4   input cols (IW)
// KERNEL_SIZE   2   square kernel side (K)
// STRIDE        2   spatial stride
// PADDING       0   zero padding on every edge
// DATA_WIDTH    32  signed element width
// ADDR_WIDTH    16  width of every RAM address port
// Derived (localparam): OH=(IH+2*PADDING-K)/STRIDE+1, OW likewise, TAPS=IC*K*K.
// PORTS
// clk        in   1           clock, rising edge
// rst        in   1           asynchronous, active-high reset
// start      in   1           begin a full convolution; sampled only in IDLE
// busy       out  1           high from first BIAS cycle through DONE
// done       out  1           one-cycle pulse when the last output has been accepted
// rd_en      out  1           read strobe for all three RAMs (data returns next cycle)
// in_addr    out  ADDR_WIDTH  b*IC*IH*IW + ic*IH*IW + ih*IW + iw (0 when tap is padding)
// w_addr     out  ADDR_WIDTH  oc*TAPS + ic*K*K + kh*K + kw
// b_addr     out  ADDR_WIDTH  oc
// in_data    in   DATA_WIDTH  input RAM read data, 1-cycle latency
// w_data     in   DATA_WIDTH  weight RAM read data, 1-cycle latency
// b_data     in   DATA_WIDTH  bias RAM read data, 1-cycle latency
// out_valid  out  1           out_data/out_addr valid
// out_ready  in   1           sink accepts when out_valid & out_ready
// out_addr   out  ADDR_WIDTH  b*OC*OH*OW + oc*OH*OW + oh*OW + ow
// out_data   out  DATA_WIDTH  finished accumulator
// BEHAVIOUR
// - Reset: all outputs 0 and state IDLE; accumulator and loop counters are 0.
// - Reset mid-operation aborts immediately; no partial output is presented.
// - Loop order, outer to inner: b, oc, oh, ow, then ic, kh, kw.
// - Tap coordinates: ih = oh*STRIDE+kh-PADDING, iw = ow*STRIDE+kw-PADDING.
// - A tap is padding when ih or iw falls outside [0,IH) or [0,IW).
//   A padding flag, delayed 1 cycle, forces the input operand to 0; the tap still consumes its cycle.
// - FSM: IDLE -> BIAS -> MAC -> LAST -> WRITE -> (BIAS | DONE) -> IDLE.
//   IDLE : busy=0. start=1 clears the counters and goes to BIAS. start in any other state is ignored.
//   BIAS : 1 cycle; rd_en=1, b_addr=oc.
//   MAC  : TAPS cycles; rd_en=1 with addresses of tap t.
//          Tap cycle 0: acc<=b_data. Tap cycle t>0: acc<=acc+prod(t-1).
//   LAST : 1 cycle; rd_en=0; acc<=acc+prod(TAPS-1).
//   WRITE: out_valid=1; out_data=acc and out_addr are stable until out_valid&out_ready.
//          No reads are issued while stalled. After acceptance: advance ow/oh/oc/b.
//          Go to BIAS, or to DONE after the final position.
//   DONE : 1 cycle; done=1, busy=1; then IDLE. A new start is accepted in the following IDLE cycle.
// - Arithmetic: two's-complement signed.
//   Product and sum are truncated to the DATA_WIDTH LSBs (wrap, no saturation).
// - Timing: one output takes TAPS+3 cycles with out_ready held high.
//   Run length is BATCH_SIZE*OC*OH*OW*(TAPS+3) cycles plus stall cycles; the DONE cycle follows.
// - rd_en is 0 outside BIAS/MAC; address outputs hold their last value when not reading.
// TESTING
// - Default params, ch0 input 1..16 and ch1 input 17..32 (row-major), weights all 1, bias 0, out_ready=1
//   -> outputs (addr:data) 0:92, 1:108, 2:156, 3:172; done pulses once, 45 cycles after start is sampled.
// - Same stimulus, out_ready low for 5 cycles at the first WRITE
//   -> out_valid held, out_data=92 stable, rd_en=0 during the stall; done 50 cycles after start.
// - IC=1, K=3, STRIDE=1, PADDING=1, input all 1, weights all 1, bias 2
//   -> OH=OW=4; corners 6, edges 8, interior 11; padding taps show in_addr=0.
// - DATA_WIDTH=8, IC=1, K=1, STRIDE=1, input 0x7F, weight 0x02, bias 0x01
//   -> each output 0xFF (wrap to -1), no saturation.
// - Assert rst during MAC of output 1 -> all outputs 0 next cycle, busy=0.
//   A new start reproduces test 1 exactly.
// - Pulse start while busy -> ignored, sequence unchanged.
//   start in the IDLE cycle after done -> a second full run.

Source files
------------

// File: rtl/conv2d_tap_scheduler.sv
// Time-multiplexed conv2d sequencer: one multiply-accumulate per cycle over every output
// position and kernel tap, with results presented on a valid/ready output port.
module conv2d_tap_scheduler #(
  parameter int BATCH_SIZE   = 1,
  parameter int IN_CHANNELS  = 2,
  parameter int OUT_CHANNELS = 1,
  parameter int IN_HEIGHT    = 4,
  parameter int IN_WIDTH     = 4,
  parameter int KERNEL_SIZE  = 2,
  parameter int STRIDE       = 2,
  parameter int PADDING      = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] in_addr,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data
);

  localparam int OH        = (IN_HEIGHT + 2*PADDING - KERNEL_SIZE) / STRIDE + 1;
  localparam int OW        = (IN_WIDTH + 2*PADDING - KERNEL_SIZE) / STRIDE + 1;
  localparam int KK        = KERNEL_SIZE * KERNEL_SIZE;
  localparam int TAPS      = IN_CHANNELS * KK;
  localparam int IN_PLANE  = IN_HEIGHT * IN_WIDTH;
  localparam int IN_IMG    = IN_CHANNELS * IN_PLANE;
  localparam int OUT_PLANE = OH * OW;
  localparam int OUT_IMG   = OUT_CHANNELS * OUT_PLANE;
  localparam int unsigned CW = 16;

  typedef enum logic [2:0] {S_IDLE, S_BIAS, S_MAC, S_LAST, S_WRITE, S_DONE} state_t;

  state_t state_q, state_d;
  logic [CW-1:0] b_q, b_d, oc_q, oc_d, oh_q, oh_d, ow_q, ow_d;
  logic [CW-1:0] ic_q, ic_d, kh_q, kh_d, kw_q, kw_d, tap_q, tap_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic pad_q, pad_d, pad_dly_q, pad_dly_d;
  logic busy_q, busy_d, done_q, done_d, rd_en_q, rd_en_d, out_valid_q, out_valid_d;
  logic [ADDR_WIDTH-1:0] in_addr_q, in_addr_d, w_addr_q, w_addr_d, b_addr_q, b_addr_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;

  int ih_c, iw_c;
  logic tap_pad_c, kw_wrap_c, kh_wrap_c, ow_wrap_c, oh_wrap_c, oc_wrap_c, last_pos_c;
  logic [ADDR_WIDTH-1:0] tap_in_addr_c, tap_w_addr_c, pos_out_addr_c;
  logic [CW-1:0] ic_nx_c, kh_nx_c, kw_nx_c, b_nx_c, oc_nx_c, oh_nx_c, ow_nx_c;
  logic [DATA_WIDTH-1:0] op_a_c, prod_c, sum_c;

  // Tap address generation, loop-counter advance and the MAC datapath.
  always_comb begin
    ih_c = int'(oh_q) * STRIDE + int'(kh_q) - PADDING;
    iw_c = int'(ow_q) * STRIDE + int'(kw_q) - PADDING;
    tap_pad_c = (ih_c < 0) || (ih_c >= IN_HEIGHT) || (iw_c < 0) || (iw_c >= IN_WIDTH);
    tap_in_addr_c = tap_pad_c ? '0 :
        ADDR_WIDTH'(int'(b_q) * IN_IMG + int'(ic_q) * IN_PLANE + ih_c * IN_WIDTH + iw_c);
    tap_w_addr_c = ADDR_WIDTH'(int'(oc_q) * TAPS + int'(ic_q) * KK +
                               int'(kh_q) * KERNEL_SIZE + int'(kw_q));
    pos_out_addr_c = ADDR_WIDTH'(int'(b_q) * OUT_IMG + int'(oc_q) * OUT_PLANE +
                                 int'(oh_q) * OW + int'(ow_q));

    kw_wrap_c = (kw_q == CW'(KERNEL_SIZE - 1));
    kh_wrap_c = kw_wrap_c && (kh_q == CW'(KERNEL_SIZE - 1));
    kw_nx_c = kw_wrap_c ? '0 : kw_q + CW'(1);
    kh_nx_c = kw_wrap_c ? (kh_wrap_c ? '0 : kh_q + CW'(1)) : kh_q;
    ic_nx_c = kh_wrap_c ? ((ic_q == CW'(IN_CHANNELS - 1)) ? '0 : ic_q + CW'(1)) : ic_q;

    ow_wrap_c = (ow_q == CW'(OW - 1));
    oh_wrap_c = ow_wrap_c && (oh_q == CW'(OH - 1));
    oc_wrap_c = oh_wrap_c && (oc_q == CW'(OUT_CHANNELS - 1));
    last_pos_c = oc_wrap_c && (b_q == CW'(BATCH_SIZE - 1));
    ow_nx_c = ow_wrap_c ? '0 : ow_q + CW'(1);
    oh_nx_c = ow_wrap_c ? (oh_wrap_c ? '0 : oh_q + CW'(1)) : oh_q;
    oc_nx_c = oh_wrap_c ? (oc_wrap_c ? '0 : oc_q + CW'(1)) : oc_q;
    b_nx_c  = oc_wrap_c ? (last_pos_c ? '0 : b_q + CW'(1)) : b_q;

    // RAM data lags the address by a cycle, so the padding mask uses the delayed flag.
    op_a_c = pad_dly_q ? '0 : in_data;
    prod_c = op_a_c * w_data;
    sum_c  = acc_q + prod_c;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    b_d = b_q; oc_d = oc_q; oh_d = oh_q; ow_d = ow_q;
    ic_d = ic_q; kh_d = kh_q; kw_d = kw_q; tap_d = tap_q;
    acc_d = acc_q; pad_d = pad_q; pad_dly_d = pad_q;
    busy_d = busy_q; done_d = 1'b0; rd_en_d = 1'b0; out_valid_d = out_valid_q;
    in_addr_d = in_addr_q; w_addr_d = w_addr_q; b_addr_d = b_addr_q; out_addr_d = out_addr_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_BIAS;
        b_d = '0; oc_d = '0; oh_d = '0; ow_d = '0;
        ic_d = '0; kh_d = '0; kw_d = '0; tap_d = '0; acc_d = '0;
        busy_d = 1'b1; rd_en_d = 1'b1; b_addr_d = '0;
      end
      S_BIAS: begin
        state_d = S_MAC;
        rd_en_d = 1'b1; in_addr_d = tap_in_addr_c; w_addr_d = tap_w_addr_c; pad_d = tap_pad_c;
        ic_d = ic_nx_c; kh_d = kh_nx_c; kw_d = kw_nx_c; tap_d = CW'(1);
      end
      S_MAC: begin
        // tap_q counts taps already issued; the first MAC cycle sees the bias word.
        acc_d = (tap_q == CW'(1)) ? b_data : sum_c;
        if (tap_q == CW'(TAPS)) begin
          state_d = S_LAST;
        end else begin
          rd_en_d = 1'b1; in_addr_d = tap_in_addr_c; w_addr_d = tap_w_addr_c; pad_d = tap_pad_c;
          ic_d = ic_nx_c; kh_d = kh_nx_c; kw_d = kw_nx_c; tap_d = tap_q + CW'(1);
        end
      end
      S_LAST: begin
        state_d = S_WRITE;
        acc_d = sum_c; out_valid_d = 1'b1; out_addr_d = pos_out_addr_c;
      end
      S_WRITE: if (out_ready) begin
        out_valid_d = 1'b0;
        b_d = b_nx_c; oc_d = oc_nx_c; oh_d = oh_nx_c; ow_d = ow_nx_c;
        if (last_pos_c) begin
          state_d = S_DONE; done_d = 1'b1;
        end else begin
          state_d = S_BIAS; rd_en_d = 1'b1; b_addr_d = ADDR_WIDTH'(oc_nx_c);
        end
      end
      S_DONE: begin
        state_d = S_IDLE; busy_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      b_q <= '0; oc_q <= '0; oh_q <= '0; ow_q <= '0;
      ic_q <= '0; kh_q <= '0; kw_q <= '0; tap_q <= '0;
      acc_q <= '0; pad_q <= 1'b0; pad_dly_q <= 1'b0;
      busy_q <= 1'b0; done_q <= 1'b0; rd_en_q <= 1'b0; out_valid_q <= 1'b0;
      in_addr_q <= '0; w_addr_q <= '0; b_addr_q <= '0; out_addr_q <= '0;
    end else begin
      state_q <= state_d;
      b_q <= b_d; oc_q <= oc_d; oh_q <= oh_d; ow_q <= ow_d;
      ic_q <= ic_d; kh_q <= kh_d; kw_q <= kw_d; tap_q <= tap_d;
      acc_q <= acc_d; pad_q <= pad_d; pad_dly_q <= pad_dly_d;
      busy_q <= busy_d; done_q <= done_d; rd_en_q <= rd_en_d; out_valid_q <= out_valid_d;
      in_addr_q <= in_addr_d; w_addr_q <= w_addr_d; b_addr_q <= b_addr_d; out_addr_q <= out_addr_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_en     = rd_en_q;
  assign in_addr   = in_addr_q;
  assign w_addr    = w_addr_q;
  assign b_addr    = b_addr_q;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = acc_q;

endmodule
